// File: rtl/wb_retire_queue_pkg.sv
// Shared types for the writeback/retire queue: default field widths and the
// packed queue-entry layout used by the stage and its tooling.
package wb_retire_queue_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_NREG_W = 5;
  localparam int DEF_DEPTH  = 4;
  localparam int WSTRB_W    = DEF_XLEN / 8;

  typedef struct packed {
    logic                  rf_we;
    logic [WSTRB_W-1:0]    wstrb;
    logic [DEF_NREG_W-1:0] dest;
    logic [DEF_XLEN-1:0]   pc;
    logic [DEF_XLEN-1:0]   result;
  } entry_t;

endpackage

// File: rtl/wb_fwd_scan.sv
// Combinational youngest-first forwarding lookup over the retire queue.
// Slots are walked oldest to youngest from the head, so the last match wins.
module wb_fwd_scan #(
  parameter int XLEN   = 32,
  parameter int NREG_W = 5,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             vld,
  input  logic [DEPTH-1:0]             we,
  input  logic [DEPTH-1:0]             strb_full,
  input  logic [DEPTH-1:0][NREG_W-1:0] dest,
  input  logic [DEPTH-1:0][XLEN-1:0]   result,
  input  logic [PTR_W-1:0]             head_idx,
  input  logic [NREG_W-1:0]            raddr,
  output logic                         hit,
  output logic                         stall,
  output logic [XLEN-1:0]              data
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    hit   = 1'b0;
    stall = 1'b0;
    data  = '0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_idx + PTR_W'(k);
      if (vld[idx] && we[idx] && (dest[idx] == raddr) && (raddr != '0)) begin
        hit   = strb_full[idx];
        stall = !strb_full[idx];
        data  = result[idx];
      end
    end
  end

endmodule

// File: rtl/wb_retire_queue.sv
// Writeback/retire stage: in-order DEPTH-entry queue between MEM and the RF/trace.
// Handshake: a MEM->WB transfer happens in any cycle where ms_to_ws_valid and
// ws_allow_in are both high; ws_allow_in depends on trace_ready, never on ms_to_ws_valid.
module wb_retire_queue
  import wb_retire_queue_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int NREG_W = DEF_NREG_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int SW    = XLEN / 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ms_to_ws_valid,
  output logic              ws_allow_in,
  input  logic              in_rf_we,
  input  logic [SW-1:0]     in_wstrb,
  input  logic [NREG_W-1:0] in_dest,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_result,
  input  logic              trace_ready,
  output logic [SW-1:0]     rf_we_out,
  output logic [NREG_W-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              trace_valid,
  output logic [XLEN-1:0]   trace_pc,
  input  logic [NREG_W-1:0] fwd_raddr,
  output logic              fwd_hit,
  output logic              fwd_stall,
  output logic [XLEN-1:0]   fwd_data,
  output logic [PTR_W:0]    occupancy
);

  logic [PTR_W:0]                head, tail;
  logic [PTR_W-1:0]              head_idx, tail_idx;
  logic [DEPTH-1:0]              vld;
  logic [DEPTH-1:0]              we_q;
  logic [DEPTH-1:0]              strb_full;
  logic [DEPTH-1:0][SW-1:0]      wstrb_q;
  logic [DEPTH-1:0][NREG_W-1:0]  dest_q;
  logic [DEPTH-1:0][XLEN-1:0]    pc_q;
  logic [DEPTH-1:0][XLEN-1:0]    res_q;
  logic                          full, retire, enq;

  assign head_idx  = head[PTR_W-1:0];
  assign tail_idx  = tail[PTR_W-1:0];
  // The extra wrap bit makes tail-head the true count, so full is count==DEPTH.
  assign occupancy = tail - head;
  assign full      = (occupancy == (PTR_W+1)'(DEPTH));

  assign trace_valid = vld[head_idx];
  // No RF write may escape during a reset cycle, even with a valid head.
  assign retire      = trace_valid && trace_ready && !rst;
  assign ws_allow_in = !full || retire;
  assign enq         = ms_to_ws_valid && ws_allow_in;

  assign trace_pc  = trace_valid ? pc_q[head_idx] : '0;
  assign rf_waddr  = trace_valid ? dest_q[head_idx] : '0;
  assign rf_wdata  = trace_valid ? res_q[head_idx] : '0;
  assign rf_we_out = (retire && we_q[head_idx] && (dest_q[head_idx] != '0))
                     ? wstrb_q[head_idx] : '0;

  always_comb begin
    strb_full = '0;
    for (int i = 0; i < DEPTH; i++) strb_full[i] = &wstrb_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      vld  <= '0;
    end else begin
      if (retire) begin
        vld[head_idx] <= 1'b0;
        head          <= head + (PTR_W+1)'(1);
      end
      // A full queue enqueues into the slot being retired; the set must win.
      if (enq) begin
        vld[tail_idx] <= 1'b1;
        tail          <= tail + (PTR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq && !rst) begin
      we_q[tail_idx]    <= in_rf_we;
      wstrb_q[tail_idx] <= in_wstrb;
      dest_q[tail_idx]  <= in_dest;
      pc_q[tail_idx]    <= in_pc;
      res_q[tail_idx]   <= in_result;
    end
  end

  wb_fwd_scan #(
    .XLEN  (XLEN),
    .NREG_W(NREG_W),
    .DEPTH (DEPTH)
  ) u_fwd_scan (
    .vld      (vld),
    .we       (we_q),
    .strb_full(strb_full),
    .dest     (dest_q),
    .result   (res_q),
    .head_idx (head_idx),
    .raddr    (fwd_raddr),
    .hit      (fwd_hit),
    .stall    (fwd_stall),
    .data     (fwd_data)
  );

endmodule

// File: tb/tb_wb_retire_queue.sv
// Directed bench for wb_retire_queue: queue-based reference model checked every
// cycle, plus literal expectations for the hand-worked scenarios.
module tb_wb_retire_queue;
  import wb_retire_queue_pkg::*;

  logic        clk;
  logic        rst;
  logic        ms_to_ws_valid;
  logic        ws_allow_in;
  logic        in_rf_we;
  logic [3:0]  in_wstrb;
  logic [4:0]  in_dest;
  logic [31:0] in_pc;
  logic [31:0] in_result;
  logic        trace_ready;
  logic [3:0]  rf_we_out;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [4:0]  fwd_raddr;
  logic        fwd_hit;
  logic        fwd_stall;
  logic [31:0] fwd_data;
  logic [2:0]  occupancy;

  int n_pass  = 0;
  int n_total = 0;
  bit armed   = 0;

  wb_retire_queue dut (
    .clk           (clk),
    .rst           (rst),
    .ms_to_ws_valid(ms_to_ws_valid),
    .ws_allow_in   (ws_allow_in),
    .in_rf_we      (in_rf_we),
    .in_wstrb      (in_wstrb),
    .in_dest       (in_dest),
    .in_pc         (in_pc),
    .in_result     (in_result),
    .trace_ready   (trace_ready),
    .rf_we_out     (rf_we_out),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .trace_valid   (trace_valid),
    .trace_pc      (trace_pc),
    .fwd_raddr     (fwd_raddr),
    .fwd_hit       (fwd_hit),
    .fwd_stall     (fwd_stall),
    .fwd_data      (fwd_data),
    .occupancy     (occupancy)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic we, input logic [3:0] s,
                       input logic [4:0] d, input logic [31:0] pc, input logic [31:0] r);
    ms_to_ws_valid = v;
    in_rf_we       = we;
    in_wstrb       = s;
    in_dest        = d;
    in_pc          = pc;
    in_result      = r;
  endtask

  // reference model: the queue contents in age order, front = oldest
  entry_t mq[$];
  entry_t m_in;
  bit     m_ret, m_allow;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
    end else begin
      m_ret   = (mq.size() > 0) && trace_ready;
      m_allow = (mq.size() < DEF_DEPTH) || m_ret;
      m_in    = '{rf_we: in_rf_we, wstrb: in_wstrb, dest: in_dest, pc: in_pc, result: in_result};
      if (m_ret) void'(mq.pop_front());
      if (ms_to_ws_valid && m_allow) mq.push_back(m_in);
    end
  end

  // scoreboard compare: every cycle, away from the active edge
  bit          e_ret, e_hit, e_stall, e_found;
  logic [31:0] e_data;
  logic [3:0]  e_we;

  always @(negedge clk) begin
    if (armed) begin
      e_ret = (mq.size() > 0) && trace_ready && !rst;
      e_we  = 4'h0;
      if (e_ret && mq[0].rf_we && mq[0].dest != 5'd0) e_we = mq[0].wstrb;
      e_found = 0; e_hit = 0; e_stall = 0; e_data = 32'h0;
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!e_found && mq[i].rf_we && mq[i].dest == fwd_raddr && fwd_raddr != 5'd0) begin
          e_found = 1;
          e_hit   = (mq[i].wstrb == 4'hF);
          e_stall = !e_hit;
          e_data  = mq[i].result;
        end
      end
      chk("occupancy", 32'(occupancy), 32'(mq.size()));
      chk("ws_allow_in", 32'(ws_allow_in), 32'((mq.size() < DEF_DEPTH) || e_ret));
      chk("trace_valid", 32'(trace_valid), 32'(mq.size() > 0));
      chk("rf_we_out", 32'(rf_we_out), 32'(e_we));
      if (mq.size() > 0) begin
        chk("trace_pc", trace_pc, mq[0].pc);
        chk("rf_waddr", 32'(rf_waddr), 32'(mq[0].dest));
        chk("rf_wdata", rf_wdata, mq[0].result);
      end
      chk("fwd_hit", 32'(fwd_hit), 32'(e_hit));
      chk("fwd_stall", 32'(fwd_stall), 32'(e_stall));
      if (!e_stall) chk("fwd_data", fwd_data, e_data);
    end
  end

  logic [3:0] strb_tab [8] = '{4'hF, 4'h1, 4'h3, 4'hF, 4'hC, 4'hF, 4'h0, 4'hF};

  initial begin
    rst = 1'b1;
    trace_ready = 1'b0;
    fwd_raddr = 5'd0;
    drive(0, 0, 4'h0, 5'd0, 32'h0, 32'h0);
    cyc();
    armed = 1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_allow", 32'(ws_allow_in), 32'd1);
    chk("rst_trace_valid", 32'(trace_valid), 32'd0);
    chk("rst_rf_we", 32'(rf_we_out), 32'd0);

    // single entry, one-cycle enqueue-to-retire latency
    cyc();
    trace_ready = 1'b1;
    drive(1, 1, 4'hF, 5'd5, 32'h1c000000, 32'h1234);
    @(negedge clk);
    chk("lat_no_trace", 32'(trace_valid), 32'd0);
    cyc();
    ms_to_ws_valid = 1'b0;
    @(negedge clk);
    chk("first_rf_we", 32'(rf_we_out), 32'hF);
    chk("first_waddr", 32'(rf_waddr), 32'd5);
    chk("first_wdata", rf_wdata, 32'h1234);
    chk("first_pc", trace_pc, 32'h1c000000);

    // fill with trace stalled, 5th held, then accepted with the first retire
    cyc();
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 4'hF, 5'(i + 1), 32'h100 + 32'(i) * 32'h10, 32'(i));
      @(negedge clk);
      if (i == 4) begin
        chk("full_allow", 32'(ws_allow_in), 32'd0);
        chk("full_occ", 32'(occupancy), 32'd4);
      end else begin
        cyc();
      end
    end
    cyc();
    trace_ready = 1'b1;
    @(negedge clk);
    chk("full_retire_allow", 32'(ws_allow_in), 32'd1);
    chk("full_retire_pc", trace_pc, 32'h100);
    cyc();
    ms_to_ws_valid = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      chk("order_pc", trace_pc, 32'h100 + 32'(j) * 32'h10);
      chk("order_occ", 32'(occupancy), 32'(5 - j));
      cyc();
    end

    // forwarding: youngest full match, r0, partial strobe
    trace_ready = 1'b0;
    drive(1, 1, 4'hF, 5'd3, 32'h180, 32'hA);
    cyc();
    drive(1, 1, 4'hF, 5'd3, 32'h184, 32'hB);
    cyc();
    ms_to_ws_valid = 1'b0;
    fwd_raddr = 5'd3;
    @(negedge clk);
    chk("fwd3_hit", 32'(fwd_hit), 32'd1);
    chk("fwd3_data", fwd_data, 32'hB);
    fwd_raddr = 5'd0;
    #1;
    chk("fwd0_hit", 32'(fwd_hit), 32'd0);
    chk("fwd0_data", fwd_data, 32'h0);
    cyc();
    drive(1, 1, 4'hF, 5'd7, 32'h188, 32'h77);
    cyc();
    drive(1, 1, 4'h3, 5'd7, 32'h18c, 32'h78);
    cyc();
    ms_to_ws_valid = 1'b0;
    fwd_raddr = 5'd7;
    @(negedge clk);
    chk("fwd7_stall", 32'(fwd_stall), 32'd1);
    chk("fwd7_hit", 32'(fwd_hit), 32'd0);
    cyc();
    trace_ready = 1'b1;
    fwd_raddr = 5'd3;
    cyc();
    @(negedge clk);
    chk("fwd_retiring_hit", 32'(fwd_hit), 32'd1);
    chk("fwd_retiring_data", fwd_data, 32'hB);
    cyc(); cyc(); cyc();

    // r0 destination: traced and dequeued, no RF write
    drive(1, 1, 4'hF, 5'd0, 32'h200, 32'hDEAD);
    cyc();
    ms_to_ws_valid = 1'b0;
    @(negedge clk);
    chk("r0_trace_valid", 32'(trace_valid), 32'd1);
    chk("r0_rf_we", 32'(rf_we_out), 32'd0);
    chk("r0_pc", trace_pc, 32'h200);
    cyc();

    // reset with three entries queued
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 4'hF, 5'(9 + i), 32'h240 + 32'(i) * 32'h4, 32'(i));
      cyc();
    end
    ms_to_ws_valid = 1'b0;
    rst = 1'b1;
    trace_ready = 1'b1;
    @(negedge clk);
    chk("rstq_no_write", 32'(rf_we_out), 32'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rstq_occ", 32'(occupancy), 32'd0);
    chk("rstq_trace_valid", 32'(trace_valid), 32'd0);

    // sustained streaming with mixed write enables and strobes
    cyc();
    for (int i = 0; i < 8; i++) begin
      drive(1, 1'(i % 2 == 0 || i == 3), strb_tab[i], 5'(12 + i), 32'h300 + 32'(i) * 32'h4,
            32'(i) * 32'h11111111);
      fwd_raddr = 5'(11 + i);
      @(negedge clk);
      chk("stream_allow", 32'(ws_allow_in), 32'd1);
      cyc();
    end
    ms_to_ws_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("stream_drained", 32'(occupancy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
